// File: rtl/soc_bus_pkg.sv
// Shared definitions for the SoC bus fabric: FSM encoding, default address map
// constants and a helper that sizes a slot index from the slot count.
package soc_bus_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2
  } bus_state_t;

  localparam logic [31:0] DEFAULT_BASE_ADDR  = 32'h0040_0000;
  localparam int          DEFAULT_SLOT_SHIFT = 16;
  localparam logic [31:0] DEFAULT_ERR_DATA   = 32'hDEAD_BEEF;

  // Width of a binary index able to address num_slots slots (at least 1 bit).
  function automatic int sel_width(input int num_slots);
    return (num_slots <= 2) ? 1 : $clog2(num_slots);
  endfunction

endpackage

// File: rtl/soc_bus_decode.sv
// Address decoder: maps a CPU address to a one-hot slot vector. Slots
// 0..NUM_SLAVES-2 are fixed-size windows starting at BASE_ADDR; every address
// outside those windows falls through to the default slot (NUM_SLAVES-1).
module soc_bus_decode
  import soc_bus_pkg::*;
#(
  parameter int          NUM_SLAVES = 7,
  parameter logic [31:0] BASE_ADDR  = DEFAULT_BASE_ADDR,
  parameter int          SLOT_SHIFT = DEFAULT_SLOT_SHIFT
) (
  input  logic [31:0]           addr,
  output logic [NUM_SLAVES-1:0] sel
);

  localparam logic [31:0] BASE_PAGE = BASE_ADDR >> SLOT_SHIFT;

  logic [31:0] page;
  logic        hit;

  // Compare the address page against each peripheral window, default on miss.
  always_comb begin
    page = addr >> SLOT_SHIFT;
    sel  = '0;
    hit  = 1'b0;
    for (int i = 0; i < NUM_SLAVES - 1; i++) begin
      if (page == BASE_PAGE + 32'(i)) begin
        sel[i] = 1'b1;
        hit    = 1'b1;
      end
    end
    if (!hit) begin
      sel[NUM_SLAVES-1] = 1'b1;
    end
  end

endmodule

// File: rtl/soc_bus_fabric.sv
// SoC bus fabric: decodes CPU accesses onto NUM_SLAVES slots, holds the slave
// select and qualifiers for the whole transaction, waits on per-slot ready,
// returns registered read data and forces completion with an error response
// when a slave never answers. A sticky record keeps the first faulting address.
module soc_bus_fabric
  import soc_bus_pkg::*;
#(
  parameter int                    NUM_SLAVES = 7,
  parameter logic [31:0]           BASE_ADDR  = DEFAULT_BASE_ADDR,
  parameter int                    SLOT_SHIFT = DEFAULT_SLOT_SHIFT,
  parameter logic [NUM_SLAVES-1:0] READY_MASK = '1,
  parameter logic [7:0]            TIMEOUT    = 8'd255,
  parameter logic [31:0]           ERR_DATA   = DEFAULT_ERR_DATA
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [31:0]                mem_addr,
  input  logic [31:0]                mem_wdata,
  input  logic [3:0]                 mem_wmask,
  input  logic                       mem_rstrb,
  output logic [31:0]                mem_rdata,
  output logic                       mem_rbusy,
  output logic                       mem_wbusy,
  output logic [NUM_SLAVES-1:0]      s_cs,
  output logic                       s_rd,
  output logic                       s_wr,
  output logic [31:0]                s_addr,
  output logic [31:0]                s_wdata,
  output logic [3:0]                 s_wmask,
  input  logic [32*NUM_SLAVES-1:0]   s_dout,
  input  logic [NUM_SLAVES-1:0]      s_ready,
  input  logic                       err_clr,
  output logic                       bus_err,
  output logic [31:0]                bus_err_addr
);

  localparam int IDX_W = sel_width(NUM_SLAVES);

  bus_state_t            state;
  bus_state_t            state_next;

  logic [NUM_SLAVES-1:0] dec_sel;
  logic [NUM_SLAVES-1:0] sel_reg;
  logic [31:0]           addr_reg;
  logic [31:0]           wdata_reg;
  logic [3:0]            wmask_reg;
  logic [7:0]            wait_cnt;

  logic                  req_wr;
  logic                  req_rd;
  logic                  in_wait;
  logic [NUM_SLAVES-1:0] eff_ready;
  logic                  sel_ready;
  logic                  timing_out;
  logic                  done;
  logic [IDX_W-1:0]      sel_idx;
  logic [31:0]           rdata_slice;

  soc_bus_decode #(
    .NUM_SLAVES (NUM_SLAVES),
    .BASE_ADDR  (BASE_ADDR),
    .SLOT_SHIFT (SLOT_SHIFT)
  ) u_decode (
    .addr (mem_addr),
    .sel  (dec_sel)
  );

  // Classify the incoming request; a write masks a simultaneous read strobe.
  always_comb begin
    req_wr = |mem_wmask;
    req_rd = mem_rstrb & ~req_wr;
  end

  // Per-slot effective ready: real ready where wired, else ready on the first wait cycle.
  always_comb begin
    eff_ready = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      eff_ready[i] = READY_MASK[i] ? s_ready[i] : (wait_cnt == 8'd0);
    end
  end

  // Completion and watchdog: ready from the selected slot, or the wait budget is spent.
  always_comb begin
    in_wait    = (state != IDLE);
    sel_ready  = in_wait && (|(sel_reg & eff_ready));
    timing_out = in_wait && !sel_ready && (wait_cnt == TIMEOUT - 8'd1);
    done       = sel_ready || timing_out;
  end

  // Convert the latched one-hot select into an index and pick that slot's read data.
  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (sel_reg[i]) begin
        sel_idx = IDX_W'(i);
      end
    end
    rdata_slice = s_dout[32*sel_idx +: 32];
  end

  // Next-state logic: start a transaction from IDLE, return to IDLE on completion.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (req_wr) begin
          state_next = WR_WAIT;
        end else if (req_rd) begin
          state_next = RD_WAIT;
        end
      end
      RD_WAIT, WR_WAIT: begin
        if (done) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Capture the request so the slave sees stable address/data/select while it works.
  always_ff @(posedge clk) begin
    if (reset) begin
      sel_reg   <= '0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      wmask_reg <= '0;
    end else if (state == IDLE && (req_wr || req_rd)) begin
      sel_reg   <= dec_sel;
      addr_reg  <= mem_addr;
      wdata_reg <= mem_wdata;
      wmask_reg <= mem_wmask;
    end
  end

  // Wait-cycle counter: runs while a transaction is pending, clears when it ends.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (in_wait && !done) begin
      wait_cnt <= wait_cnt + 8'd1;
    end else begin
      wait_cnt <= '0;
    end
  end

  // Read data register: slave data on a normal finish, error pattern on timeout.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_rdata <= '0;
    end else if (state == RD_WAIT) begin
      if (sel_ready) begin
        mem_rdata <= rdata_slice;
      end else if (timing_out) begin
        mem_rdata <= ERR_DATA;
      end
    end
  end

  // Sticky error record; a timeout beats a same-cycle clear and then takes the new address.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus_err      <= 1'b0;
      bus_err_addr <= '0;
    end else if (timing_out) begin
      bus_err <= 1'b1;
      if (!bus_err || err_clr) begin
        bus_err_addr <= addr_reg;
      end
    end else if (err_clr) begin
      bus_err      <= 1'b0;
      bus_err_addr <= '0;
    end
  end

  // Slave-side outputs and CPU busy flags come straight from state and the latches.
  always_comb begin
    mem_rbusy = (state == RD_WAIT);
    mem_wbusy = (state == WR_WAIT);
    s_cs      = in_wait ? sel_reg : '0;
    s_rd      = (state == RD_WAIT);
    s_wr      = (state == WR_WAIT);
    s_addr    = addr_reg;
    s_wdata   = wdata_reg;
    s_wmask   = (state == WR_WAIT) ? wmask_reg : 4'h0;
  end

endmodule

// File: tb/tb_soc_bus_fabric.sv
// Scoreboard bench for soc_bus_fabric: stimulus computes each transaction's
// expected outcome from the address map and slave latency, a monitor checks it.
module tb_soc_bus_fabric;

  localparam int NS = 7;
  localparam logic [31:0] ERR_WORD = 32'hDEAD_BEEF;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [31:0]     mem_addr = '0;
  logic [31:0]     mem_wdata = '0;
  logic [3:0]      mem_wmask = '0;
  logic            mem_rstrb = 1'b0;
  logic [31:0]     mem_rdata;
  logic            mem_rbusy;
  logic            mem_wbusy;
  logic [NS-1:0]   s_cs;
  logic            s_rd;
  logic            s_wr;
  logic [31:0]     s_addr;
  logic [31:0]     s_wdata;
  logic [3:0]      s_wmask;
  logic [32*NS-1:0] s_dout;
  logic [NS-1:0]   s_ready = '0;
  logic            err_clr = 1'b0;
  logic            bus_err;
  logic [31:0]     bus_err_addr;

  typedef struct {
    bit          wr;
    logic [NS-1:0] cs;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    int          waits;
    logic [31:0] rdata;
    bit          err;
    logic [31:0] err_addr;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          mon_cycles;
  bit          mon_active = 1'b0;
  int          n_checks = 0;
  int          n_pass = 0;
  logic [31:0] dout_v [NS];
  int          lat = 1;
  int          resp_cnt = 0;
  logic [31:0] m_rdata = '0;
  bit          m_err = 1'b0;
  logic [31:0] m_err_addr = '0;

  soc_bus_fabric dut (
    .clk          (clk),
    .reset        (reset),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_wmask    (mem_wmask),
    .mem_rstrb    (mem_rstrb),
    .mem_rdata    (mem_rdata),
    .mem_rbusy    (mem_rbusy),
    .mem_wbusy    (mem_wbusy),
    .s_cs         (s_cs),
    .s_rd         (s_rd),
    .s_wr         (s_wr),
    .s_addr       (s_addr),
    .s_wdata      (s_wdata),
    .s_wmask      (s_wmask),
    .s_dout       (s_dout),
    .s_ready      (s_ready),
    .err_clr      (err_clr),
    .bus_err      (bus_err),
    .bus_err_addr (bus_err_addr)
  );

  always #5 clk = ~clk;

  // Pack the per-slot read words onto the flat slave data bus.
  always_comb begin
    s_dout = '0;
    for (int i = 0; i < NS; i++) s_dout[32*i +: 32] = dout_v[i];
  end

  // Slave model: selected slot answers after lat wait cycles (never if lat==0); others toggle randomly.
  always begin
    @(negedge clk);
    if (s_cs != '0) resp_cnt++;
    else resp_cnt = 0;
    s_ready = (NS'($urandom) & ~s_cs) | ((lat != 0 && resp_cnt >= lat) ? s_cs : '0);
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Address map from the memory layout: 64 KiB windows from 0x0040_0000, else default slot.
  function automatic int expected_slot(input logic [31:0] addr);
    int page;
    page = int'(addr >> 16);
    if (page >= 'h40 && page < 'h40 + NS - 1) return page - 'h40;
    return NS - 1;
  endfunction

  // Monitor: whenever the fabric goes busy, pop the expected transaction and follow it to the end.
  always begin
    @(negedge clk);
    if (mem_rbusy || mem_wbusy) begin
      if (sb.size() == 0) begin
        check_output("spurious_busy", {31'b0, mem_rbusy | mem_wbusy}, 32'h0);
      end else begin
        mon_e = sb.pop_front();
        mon_active = 1'b1;
        mon_cycles = 0;
        while ((mem_rbusy || mem_wbusy) && mon_cycles < 300) begin
          mon_cycles++;
          check_output("mem_rbusy", {31'b0, mem_rbusy}, {31'b0, !mon_e.wr});
          check_output("mem_wbusy", {31'b0, mem_wbusy}, {31'b0, mon_e.wr});
          check_output("s_cs", 32'(s_cs), 32'(mon_e.cs));
          check_output("s_rd", {31'b0, s_rd}, {31'b0, !mon_e.wr});
          check_output("s_wr", {31'b0, s_wr}, {31'b0, mon_e.wr});
          check_output("s_addr", s_addr, mon_e.addr);
          check_output("s_wdata", s_wdata, mon_e.wdata);
          check_output("s_wmask", 32'(s_wmask), mon_e.wr ? 32'(mon_e.wmask) : 32'h0);
          @(negedge clk);
        end
        check_output("wait_cycles", 32'(mon_cycles), 32'(mon_e.waits));
        check_output("s_cs_after", 32'(s_cs), 32'h0);
        check_output("s_rd_wr_after", {30'b0, s_rd, s_wr}, 32'h0);
        check_output("mem_rdata", mem_rdata, mon_e.rdata);
        check_output("bus_err", {31'b0, bus_err}, {31'b0, mon_e.err});
        check_output("bus_err_addr", bus_err_addr, mon_e.err_addr);
        mon_active = 1'b0;
      end
    end
  end

  // Issue one CPU request, predict its outcome, optionally reset mid-way or clear errors at timeout.
  task automatic apply_stimulus(input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [3:0] wmask, input bit rstrb, input int latency,
                                input bit aborted, input bit clr_at_end);
    exp_t e;
    int   slot;
    bit   tmo;
    for (int i = 0; i < NS; i++) dout_v[i] = $urandom;
    lat  = latency;
    slot = expected_slot(addr);
    tmo  = !(latency >= 1 && latency <= 255);
    e.wr    = (wmask != 4'h0);
    e.cs    = NS'(1) << slot;
    e.addr  = addr;
    e.wdata = wdata;
    e.wmask = wmask;
    if (aborted) begin
      e.waits = 2;
      m_rdata = '0;
      m_err = 1'b0;
      m_err_addr = '0;
    end else begin
      e.waits = tmo ? 255 : latency;
      if (!e.wr) m_rdata = tmo ? ERR_WORD : dout_v[slot];
      if (tmo) begin
        if (!m_err || clr_at_end) m_err_addr = addr;
        m_err = 1'b1;
      end else if (clr_at_end) begin
        m_err = 1'b0;
        m_err_addr = '0;
      end
    end
    e.rdata = m_rdata;
    e.err = m_err;
    e.err_addr = m_err_addr;
    sb.push_back(e);
    @(negedge clk);
    mem_addr  = addr;
    mem_wdata = wdata;
    mem_wmask = wmask;
    mem_rstrb = rstrb;
    @(posedge clk);
    #1;
    mem_wmask = 4'h0;
    mem_rstrb = 1'b0;
    mem_addr  = $urandom;
    mem_wdata = $urandom;
    if (aborted) begin
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
    end
    if (clr_at_end) begin
      repeat (254) @(posedge clk);
      #1 err_clr = 1'b1;
      @(posedge clk);
      #1 err_clr = 1'b0;
    end
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (sb.size() == 0 && !mon_active) break;
    end
    check_output("drain", 32'(sb.size()), 32'h0);
    sb.delete();
  endtask

  // Pulse err_clr between transactions and confirm the record empties.
  task automatic clear_errors();
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    m_err = 1'b0;
    m_err_addr = '0;
    check_output("clr_bus_err", {31'b0, bus_err}, 32'h0);
    check_output("clr_bus_err_addr", bus_err_addr, 32'h0);
  endtask

  initial begin
    int   kind;
    logic [31:0] a;
    for (int i = 0; i < NS; i++) dout_v[i] = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_output("rst_mem_rdata", mem_rdata, 32'h0);
    check_output("rst_busy", {30'b0, mem_rbusy, mem_wbusy}, 32'h0);
    check_output("rst_s_cs", 32'(s_cs), 32'h0);
    check_output("rst_s_rd_wr", {30'b0, s_rd, s_wr}, 32'h0);
    check_output("rst_s_addr", s_addr, 32'h0);
    check_output("rst_s_wdata", s_wdata, 32'h0);
    check_output("rst_s_wmask", 32'(s_wmask), 32'h0);
    check_output("rst_bus_err", {31'b0, bus_err}, 32'h0);
    check_output("rst_bus_err_addr", bus_err_addr, 32'h0);
    reset = 1'b0;

    apply_stimulus(32'h0041_0004, 32'h0, 4'h0, 1'b1, 1, 1'b0, 1'b0);
    apply_stimulus(32'h0042_0000, 32'hA5A5_A5A5, 4'hF, 1'b0, 4, 1'b0, 1'b0);
    apply_stimulus(32'h0000_1000, 32'h0, 4'h0, 1'b1, 2, 1'b0, 1'b0);
    apply_stimulus(32'h0046_0008, 32'h0, 4'h0, 1'b1, 1, 1'b0, 1'b0);
    apply_stimulus(32'h003F_FFFC, 32'h1111_2222, 4'h3, 1'b0, 3, 1'b0, 1'b0);
    apply_stimulus(32'h0043_0010, 32'h0, 4'h0, 1'b1, 0, 1'b0, 1'b0);
    apply_stimulus(32'h0044_0020, 32'h5555_AAAA, 4'hC, 1'b0, 0, 1'b0, 1'b0);
    clear_errors();
    apply_stimulus(32'h0045_0100, 32'hCAFE_F00D, 4'h1, 1'b1, 2, 1'b0, 1'b0);
    apply_stimulus(32'h0045_0200, 32'h0, 4'h0, 1'b1, 5, 1'b1, 1'b0);
    apply_stimulus(32'h0040_0040, 32'h0, 4'h0, 1'b1, 1, 1'b0, 1'b0);
    apply_stimulus(32'h0040_0080, 32'h0, 4'h0, 1'b1, 0, 1'b0, 1'b0);
    apply_stimulus(32'h0041_00C0, 32'h0, 4'h0, 1'b1, 0, 1'b0, 1'b1);
    clear_errors();
    apply_stimulus(32'h0042_0300, 32'h0, 4'h0, 1'b1, 255, 1'b0, 1'b0);

    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 2);
      if ($urandom_range(0, 3) != 0) a = 32'h0040_0000 + (32'($urandom_range(0, 7)) << 16) + ($urandom & 32'hFFFC);
      else a = $urandom;
      case (kind)
        0: apply_stimulus(a, $urandom, 4'h0, 1'b1, $urandom_range(1, 8), 1'b0, 1'b0);
        1: apply_stimulus(a, $urandom, 4'($urandom_range(1, 15)), 1'b0, $urandom_range(1, 8), 1'b0, 1'b0);
        default: apply_stimulus(a, $urandom, 4'($urandom_range(1, 15)), 1'b1, $urandom_range(1, 8), 1'b0, 1'b0);
      endcase
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL global_timeout: simulation did not complete, checks %0d passed of %0d", n_pass, n_checks);
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
